// File: rtl/demux_8bits_buffered.sv
// One byte stream steered onto four buffered valid/ready channels (a..d),
// targeted either by sel or by a round-robin pointer that only moves on accepts.
module demux_8bits_buffered #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
  input  logic             rr_mode,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [1:0]            r_rr_ptr;
  logic [1:0]            w_target;
  logic                  w_accept;
  logic [3:0]            w_full;
  logic [3:0]            w_valid;
  logic [3:0]            w_pop_req;
  logic [3:0][WIDTH-1:0] w_head;

  assign w_pop_req = {d_ready, c_ready, b_ready, a_ready};
  assign w_target  = rr_mode ? r_rr_ptr : sel;
  // A full target stalls input even if it pops this cycle: no pass-through.
  assign in_ready  = !rst && !w_full[w_target];
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 2'd0;
    end else if (w_accept && rr_mode) begin
      r_rr_ptr <= r_rr_ptr + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]    r_wr_ptr;
      logic [AW-1:0]    r_rd_ptr;
      logic [CW-1:0]    r_count;
      logic             w_push;
      logic             w_pop;

      assign w_push      = w_accept && (w_target == 2'(gi));
      assign w_pop       = w_valid[gi] && w_pop_req[gi];
      assign w_valid[gi] = (r_count != '0);
      assign w_full[gi]  = (r_count == FULL_COUNT);
      assign w_head[gi]  = w_valid[gi] ? r_mem[r_rd_ptr] : '0;

      // Storage needs no reset: the occupancy counter decides what is visible.
      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= in_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
          if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
          end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
          end
        end
      end
    end
  endgenerate

  assign a       = w_head[0];
  assign b       = w_head[1];
  assign c       = w_head[2];
  assign d       = w_head[3];
  assign a_valid = w_valid[0];
  assign b_valid = w_valid[1];
  assign c_valid = w_valid[2];
  assign d_valid = w_valid[3];

endmodule

// File: tb/tb_demux_8bits_buffered.sv
// Bench for demux_8bits_buffered: directed scenarios plus a randomized run,
// all checked against a queue-per-channel reference model.
module tb_demux_8bits_buffered;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] sel = 2'd0;
  logic       rr_mode = 1'b0;
  logic [7:0] a, b, c, d;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic       a_ready = 1'b0, b_ready = 1'b0, c_ready = 1'b0, d_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_q [4][$];
  logic [1:0] m_rr = 2'd0;

  logic [7:0] dout [4];
  logic [3:0] dval;
  logic [3:0] drdy;

  assign dout[0] = a;
  assign dout[1] = b;
  assign dout[2] = c;
  assign dout[3] = d;
  assign dval = {d_valid, c_valid, b_valid, a_valid};
  assign drdy = {d_ready, c_ready, b_ready, a_ready};

  demux_8bits_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .rr_mode(rr_mode),
    .a(a), .b(b), .c(c), .d(d),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and apply the same edge to the model; ends at negedge.
  task automatic tick();
    logic [1:0] tgt;
    bit         acc;
    bit [3:0]   pop;
    tgt = rr_mode ? m_rr : sel;
    acc = in_valid && !rst && (m_q[tgt].size() < DEPTH);
    for (int i = 0; i < 4; i++) pop[i] = drdy[i] && (m_q[i].size() > 0);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) m_q[i].delete();
      m_rr = 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) if (pop[i]) void'(m_q[i].pop_front());
      if (acc) begin
        m_q[tgt].push_back(in_data);
        if (rr_mode) m_rr = m_rr + 2'd1;
        $display("accept ch%0d data %02h t=%0t", tgt, in_data, $time);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_ready(input logic [3:0] r);
    {d_ready, c_ready, b_ready, a_ready} = r;
  endtask

  task automatic test_reset();
    tick();
    tick();
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    n_checks++;
    if (dval !== 4'b0000) begin n_errors++; $display("FAIL reset_valid got %b exp 0000", dval); end
    n_checks++;
    if ({a, b, c, d} !== 32'h0) begin n_errors++; $display("FAIL reset_data got %h exp 0", {a, b, c, d}); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_addressed();
    logic [7:0] pat [4];
    pat[0] = 8'h00; pat[1] = 8'h0f; pat[2] = 8'hf0; pat[3] = 8'hff;
    set_ready(4'b1111);
    rr_mode = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      in_data = pat[k];
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_errors++; $display("FAIL addr_ready[%0d] got %b exp 1", k, in_ready); end
      tick();
      #1;
      n_checks++;
      if (dval !== (4'b0001 << k)) begin n_errors++; $display("FAIL addr_valid[%0d] got %b exp %b", k, dval, 4'b0001 << k); end
      n_checks++;
      if (dout[k] !== pat[k]) begin n_errors++; $display("FAIL addr_data[%0d] got %h exp %h", k, dout[k], pat[k]); end
    end
    in_valid = 1'b0;
    tick();
    #1;
    n_checks++;
    if (dval !== 4'b0000) begin n_errors++; $display("FAIL addr_drain got %b exp 0000", dval); end
  endtask

  task automatic test_round_robin();
    logic [7:0] v;
    set_ready(4'b1111);
    rr_mode = 1'b1;
    sel = 2'd3;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      v = 8'(8'h11 * (k + 1));
      in_data = v;
      tick();
      #1;
      n_checks++;
      if (dval !== (4'b0001 << (k % 4))) begin n_errors++; $display("FAIL rr_valid[%0d] got %b exp %b", k, dval, 4'b0001 << (k % 4)); end
      n_checks++;
      if (dout[k % 4] !== v) begin n_errors++; $display("FAIL rr_data[%0d] got %h exp %h", k, dout[k % 4], v); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    rr_mode = 1'b0;
    sel = 2'd2;
    set_ready(4'b1011);
    in_valid = 1'b1;
    in_data = 8'hA1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_a1 got %b exp 1", in_ready); end
    tick();
    in_data = 8'hA2;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_a2 got %b exp 1", in_ready); end
    tick();
    in_data = 8'hA3;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    tick();
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || c_valid !== 1'b1 || c !== 8'hA1) begin
      n_errors++; $display("FAIL bp_stall got ready=%b c_valid=%b c=%h exp 0 1 a1", in_ready, c_valid, c);
    end
    sel = 2'd1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_switch_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (b_valid !== 1'b1 || b !== 8'hA3) begin n_errors++; $display("FAIL bp_b_a3 got valid=%b b=%h exp 1 a3", b_valid, b); end
    c_ready = 1'b1;
    n_checks++;
    if (c_valid !== 1'b1 || c !== 8'hA1) begin n_errors++; $display("FAIL bp_c_a1 got valid=%b c=%h exp 1 a1", c_valid, c); end
    tick();
    #1;
    n_checks++;
    if (c_valid !== 1'b1 || c !== 8'hA2) begin n_errors++; $display("FAIL bp_c_a2 got valid=%b c=%h exp 1 a2", c_valid, c); end
    tick();
    #1;
    n_checks++;
    if (dval !== 4'b0000) begin n_errors++; $display("FAIL bp_drain got %b exp 0000", dval); end
  endtask

  task automatic test_push_pop();
    rr_mode = 1'b0;
    sel = 2'd0;
    set_ready(4'b1110);
    in_valid = 1'b1;
    in_data = 8'h5A;
    tick();
    in_data = 8'h6B;
    a_ready = 1'b1;
    #1;
    n_checks++;
    if (a !== 8'h5A || in_ready !== 1'b1) begin n_errors++; $display("FAIL pp_pre got a=%h ready=%b exp 5a 1", a, in_ready); end
    tick();
    in_valid = 1'b0;
    a_ready = 1'b0;
    #1;
    n_checks++;
    if (a_valid !== 1'b1 || a !== 8'h6B) begin n_errors++; $display("FAIL pp_after got valid=%b a=%h exp 1 6b", a_valid, a); end
    tick();
    #1;
    n_checks++;
    if (a_valid !== 1'b1 || a !== 8'h6B) begin n_errors++; $display("FAIL pp_hold got valid=%b a=%h exp 1 6b", a_valid, a); end
    a_ready = 1'b1;
    tick();
    #1;
    n_checks++;
    if (a_valid !== 1'b0) begin n_errors++; $display("FAIL pp_count1 got valid=%b exp 0", a_valid); end
  endtask

  task automatic test_reset_mid();
    set_ready(4'b0000);
    rr_mode = 1'b0;
    in_valid = 1'b1;
    sel = 2'd1; in_data = 8'h21; tick();
    in_data = 8'h22; tick();
    sel = 2'd0; in_data = 8'h23; tick();
    #1;
    n_checks++;
    if (dval !== 4'b0011) begin n_errors++; $display("FAIL rm_fill got %b exp 0011", dval); end
    rst = 1'b1;
    set_ready(4'b1111);
    in_data = 8'h24;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rm_ready_in_rst got %b exp 0", in_ready); end
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    set_ready(4'b0000);
    #1;
    n_checks++;
    if (dval !== 4'b0000 || {a, b, c, d} !== 32'h0) begin
      n_errors++; $display("FAIL rm_cleared got valid=%b data=%h exp 0000 0", dval, {a, b, c, d});
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rm_ready_after got %b exp 1", in_ready); end
    rr_mode = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (dval !== 4'b0001 || a !== 8'h77) begin n_errors++; $display("FAIL rm_rr_zero got valid=%b a=%h exp 0001 77", dval, a); end
    a_ready = 1'b1;
    tick();
  endtask

  task automatic test_rr_stall();
    set_ready(4'b0111);
    rr_mode = 1'b0;
    sel = 2'd3;
    in_valid = 1'b1;
    in_data = 8'hD1; tick();
    in_data = 8'hD2; tick();
    rr_mode = 1'b1;
    in_data = 8'hB1; tick();
    in_data = 8'hC1; tick();
    in_data = 8'hD3;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rs_blocked got %b exp 0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || d !== 8'hD1) begin n_errors++; $display("FAIL rs_hold[%0d] got ready=%b d=%h exp 0 d1", k, in_ready, d); end
    end
    d_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rs_full_pop got %b exp 0", in_ready); end
    tick();
    d_ready = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || d !== 8'hD2) begin n_errors++; $display("FAIL rs_unblock got ready=%b d=%h exp 1 d2", in_ready, d); end
    tick();
    in_data = 8'h99;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rs_wrap_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (a_valid !== 1'b1 || a !== 8'h99) begin n_errors++; $display("FAIL rs_wrap_a got valid=%b a=%h exp 1 99", a_valid, a); end
    set_ready(4'b1111);
    repeat (3) tick();
    #1;
    n_checks++;
    if (dval !== 4'b0000) begin n_errors++; $display("FAIL rs_drain got %b exp 0000", dval); end
  endtask

  task automatic test_random();
    logic [7:0] exp_d;
    bit         exp_r;
    logic [1:0] tgt;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst      = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      sel      = 2'($urandom_range(0, 3));
      rr_mode  = ($urandom_range(0, 1) == 1);
      set_ready(4'($urandom_range(0, 15)));
      #1;
      tgt   = rr_mode ? m_rr : sel;
      exp_r = !rst && (m_q[tgt].size() < DEPTH);
      n_checks++;
      if (in_ready !== exp_r) begin n_errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, in_ready, exp_r); end
      for (int i = 0; i < 4; i++) begin
        exp_d = (m_q[i].size() > 0) ? m_q[i][0] : 8'h00;
        n_checks++;
        if (dval[i] !== (m_q[i].size() > 0) || dout[i] !== exp_d) begin
          n_errors++;
          $display("FAIL rand_ch%0d cyc %0d got valid=%b data=%h exp %b %h", i, cyc, dval[i], dout[i], m_q[i].size() > 0, exp_d);
        end
      end
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addressed();
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_rr_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
